// File: rtl/rv_decode_ctrl_stage.sv
// Registered RV32I(+M) decode stage: builds the ID/EX control register and
// holds off fetch while a multi-cycle mul/div is in flight.
module rv_decode_ctrl_stage #(
  parameter bit          EN_MEXT = 1'b1,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        valid_e,
  output logic        reg_write_e,
  output logic        mem_write_e,
  output logic        alu_src_e,
  output logic        branch_e,
  output logic        jump_e,
  output logic        jal_jalr_sel_e,
  output logic        loadimm_sel_e,
  output logic        auipc_e,
  output logic [1:0]  result_src_e,
  output logic [4:0]  alu_control_e,
  output logic [2:0]  imm_src_e,
  output logic [2:0]  funct3_e,
  output logic        mdu_start_e,
  output logic [2:0]  mdu_op_e,
  output logic        illegal_e
);

  localparam int unsigned CNT_W = 8;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;
  localparam logic [1:0] RS_MDU = 2'b11;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       jal_jalr_sel;
    logic       loadimm_sel;
    logic       auipc;
    logic [1:0] result_src;
    logic [4:0] alu_control;
    logic [2:0] imm_src;
    logic [2:0] funct3;
    logic       mdu_start;
    logic [2:0] mdu_op;
    logic       illegal;
  } ex_t;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ex_t              dec, ex_q;
  logic             accept;
  logic             m_issue;
  logic [6:0]       funct7;
  logic [2:0]       funct3;
  logic             unused_instr;

  assign funct7       = instr_i[31:25];
  assign funct3       = instr_i[14:12];
  assign unused_instr = ^{instr_i[24:15], instr_i[11:7]};

  // ALU op for a funct3, with the instr[30] sub/sra alternates
  function automatic logic [4:0] alu_code(input logic [2:0] f3, input logic use_sub,
                                          input logic use_sra);
    logic [4:0] code;
    case (f3)
      3'b000:  code = use_sub ? ALU_SUB : ALU_ADD;
      3'b001:  code = 5'b00100;
      3'b010:  code = 5'b00101;
      3'b011:  code = 5'b01000;
      3'b100:  code = 5'b01010;
      3'b101:  code = use_sra ? 5'b00111 : 5'b01110;
      3'b110:  code = 5'b00011;
      default: code = 5'b00010;
    endcase
    return code;
  endfunction

  // Main decode of the instruction presented by IF/ID
  always_comb begin
    dec        = '0;
    dec.valid  = 1'b1;
    dec.funct3 = funct3;
    case (instr_i[6:0])
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RS_MEM;
        dec.imm_src    = IMM_I;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_S;
      end
      OP_REG: begin
        if (funct7 == F7_MULDIV) begin
          if (EN_MEXT) begin
            dec.reg_write  = 1'b1;
            dec.result_src = RS_MDU;
            dec.mdu_start  = 1'b1;
            dec.mdu_op     = funct3;
          end else begin
            dec.illegal = 1'b1;
          end
        end else if (funct7 == F7_BASE || funct7 == F7_ALT) begin
          dec.reg_write   = 1'b1;
          dec.alu_control = alu_code(funct3, instr_i[30], instr_i[30]);
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_IMM: begin
        dec.reg_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.imm_src     = IMM_I;
        dec.alu_control = alu_code(funct3, 1'b0, instr_i[30]);
      end
      OP_BRANCH: begin
        dec.branch      = 1'b1;
        dec.imm_src     = IMM_B;
        dec.alu_control = ALU_SUB;
      end
      OP_JAL: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RS_PC4;
        dec.imm_src    = IMM_J;
      end
      OP_JALR: begin
        dec.jump         = 1'b1;
        dec.reg_write    = 1'b1;
        dec.result_src   = RS_PC4;
        dec.alu_src      = 1'b1;
        dec.imm_src      = IMM_I;
        dec.jal_jalr_sel = 1'b1;
      end
      OP_LUI: begin
        dec.reg_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.loadimm_sel = 1'b1;
        dec.imm_src     = IMM_U;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.auipc     = 1'b1;
        dec.imm_src   = IMM_U;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign ready_o = ~rst & ~stall_i & ~flush_i & (state_q == IDLE);
  assign accept  = valid_i & ready_o;
  assign m_issue = accept & dec.mdu_start;
  assign busy_o  = (state_q == BUSY);

  // MDU busy FSM next state; the countdown runs through stalls
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (m_issue) begin
          state_d = BUSY;
          cnt_d   = funct3[2] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end
      end
      BUSY: begin
        if (flush_i || cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // MDU FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ID/EX register; a held copy drops mdu_start so the MDU fires once
  always_ff @(posedge clk) begin
    if (rst)                   ex_q           <= '0;
    else if (flush_i)          ex_q           <= '0;
    else if (stall_i)          ex_q.mdu_start <= 1'b0;
    else if (state_q == BUSY)  ex_q           <= '0;
    else if (accept)           ex_q           <= dec;
    else                       ex_q           <= '0;
  end

  assign valid_e        = ex_q.valid;
  assign reg_write_e    = ex_q.reg_write;
  assign mem_write_e    = ex_q.mem_write;
  assign alu_src_e      = ex_q.alu_src;
  assign branch_e       = ex_q.branch;
  assign jump_e         = ex_q.jump;
  assign jal_jalr_sel_e = ex_q.jal_jalr_sel;
  assign loadimm_sel_e  = ex_q.loadimm_sel;
  assign auipc_e        = ex_q.auipc;
  assign result_src_e   = ex_q.result_src;
  assign alu_control_e  = ex_q.alu_control;
  assign imm_src_e      = ex_q.imm_src;
  assign funct3_e       = ex_q.funct3;
  assign mdu_start_e    = ex_q.mdu_start;
  assign mdu_op_e       = ex_q.mdu_op;
  assign illegal_e      = ex_q.illegal;

endmodule

// File: tb/tb_rv_decode_ctrl_stage.sv
// Scoreboard bench for rv_decode_ctrl_stage: directed scenarios then random traffic.
module tb_rv_decode_ctrl_stage;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       jal_jalr_sel;
    logic       loadimm_sel;
    logic       auipc;
    logic [1:0] result_src;
    logic [4:0] alu_control;
    logic [2:0] imm_src;
    logic [2:0] funct3;
    logic       mdu_start;
    logic [2:0] mdu_op;
    logic       illegal;
  } tb_ex_t;

  logic        clk, rst, valid_i, stall_i, flush_i;
  logic [31:0] instr_i;
  logic        ready_o, busy_o, valid_e, reg_write_e, mem_write_e, alu_src_e;
  logic        branch_e, jump_e, jal_jalr_sel_e, loadimm_sel_e, auipc_e;
  logic [1:0]  result_src_e;
  logic [4:0]  alu_control_e;
  logic [2:0]  imm_src_e, funct3_e, mdu_op_e;
  logic        mdu_start_e, illegal_e;

  logic        valid2;
  logic [31:0] instr2;
  logic        ready2, busy2, valid_e2, reg_write2, mem_write2, alu_src2;
  logic        branch2, jump2, jal_jalr_sel2, loadimm_sel2, auipc2;
  logic [1:0]  result_src2;
  logic [4:0]  alu_control2;
  logic [2:0]  imm_src2, funct3_2, mdu_op2;
  logic        mdu_start2, illegal2;

  int total = 0;
  int bad   = 0;

  rv_decode_ctrl_stage #(.EN_MEXT(1'b1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .instr_i(instr_i), .valid_i(valid_i), .stall_i(stall_i),
    .flush_i(flush_i), .ready_o(ready_o), .busy_o(busy_o), .valid_e(valid_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .alu_src_e(alu_src_e),
    .branch_e(branch_e), .jump_e(jump_e), .jal_jalr_sel_e(jal_jalr_sel_e),
    .loadimm_sel_e(loadimm_sel_e), .auipc_e(auipc_e), .result_src_e(result_src_e),
    .alu_control_e(alu_control_e), .imm_src_e(imm_src_e), .funct3_e(funct3_e),
    .mdu_start_e(mdu_start_e), .mdu_op_e(mdu_op_e), .illegal_e(illegal_e)
  );

  rv_decode_ctrl_stage #(.EN_MEXT(1'b0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut_nom (
    .clk(clk), .rst(rst), .instr_i(instr2), .valid_i(valid2), .stall_i(1'b0),
    .flush_i(1'b0), .ready_o(ready2), .busy_o(busy2), .valid_e(valid_e2),
    .reg_write_e(reg_write2), .mem_write_e(mem_write2), .alu_src_e(alu_src2),
    .branch_e(branch2), .jump_e(jump2), .jal_jalr_sel_e(jal_jalr_sel2),
    .loadimm_sel_e(loadimm_sel2), .auipc_e(auipc2), .result_src_e(result_src2),
    .alu_control_e(alu_control2), .imm_src_e(imm_src2), .funct3_e(funct3_2),
    .mdu_start_e(mdu_start2), .mdu_op_e(mdu_op2), .illegal_e(illegal2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Instruction class: 0 load,1 store,2 reg,3 imm,4 branch,5 jal,6 jalr,7 lui,8 auipc,9 muldiv,10 illegal
  function automatic int class_of(input logic [31:0] ins, input bit en_m);
    case (ins[6:0])
      7'b0000011: return 0;
      7'b0100011: return 1;
      7'b0110011: begin
        if (ins[31:25] == 7'b0000001) return en_m ? 9 : 10;
        if (ins[31:25] == 7'b0000000 || ins[31:25] == 7'b0100000) return 2;
        return 10;
      end
      7'b0010011: return 3;
      7'b1100011: return 4;
      7'b1101111: return 5;
      7'b1100111: return 6;
      7'b0110111: return 7;
      7'b0010111: return 8;
      default:    return 10;
    endcase
  endfunction

  // {reg_write,mem_write,alu_src,branch,jump,jal_jalr_sel,loadimm_sel,auipc,result_src,imm_src}
  function automatic logic [12:0] ctl_of(input int cls);
    case (cls)
      0:       return 13'b1_0_1_0_0_0_0_0_01_000;
      1:       return 13'b0_1_1_0_0_0_0_0_00_001;
      2:       return 13'b1_0_0_0_0_0_0_0_00_000;
      3:       return 13'b1_0_1_0_0_0_0_0_00_000;
      4:       return 13'b0_0_0_1_0_0_0_0_00_010;
      5:       return 13'b1_0_0_0_1_0_0_0_10_011;
      6:       return 13'b1_0_1_0_1_1_0_0_10_000;
      7:       return 13'b1_0_1_0_0_0_1_0_00_100;
      8:       return 13'b1_0_1_0_0_0_0_1_00_100;
      9:       return 13'b1_0_0_0_0_0_0_0_11_000;
      default: return 13'b0;
    endcase
  endfunction

  function automatic logic [4:0] alu_of(input logic [2:0] f3);
    case (f3)
      3'd0: return 5'b00000;  3'd1: return 5'b00100;
      3'd2: return 5'b00101;  3'd3: return 5'b01000;
      3'd4: return 5'b01010;  3'd5: return 5'b01110;
      3'd6: return 5'b00011;  default: return 5'b00010;
    endcase
  endfunction

  function automatic tb_ex_t model(input logic [31:0] ins, input bit en_m);
    tb_ex_t e;
    int     cls;
    e        = '0;
    cls      = class_of(ins, en_m);
    e.valid  = 1'b1;
    e.funct3 = ins[14:12];
    {e.reg_write, e.mem_write, e.alu_src, e.branch, e.jump, e.jal_jalr_sel,
     e.loadimm_sel, e.auipc, e.result_src, e.imm_src} = ctl_of(cls);
    if (cls == 2 || cls == 3) begin
      e.alu_control = alu_of(ins[14:12]);
      if (ins[30] && ins[14:12] == 3'd5) e.alu_control = 5'b00111;
      if (cls == 2 && ins[30] && ins[14:12] == 3'd0) e.alu_control = 5'b00001;
    end
    if (cls == 4) e.alu_control = 5'b00001;
    if (cls == 9) begin
      e.mdu_start = 1'b1;
      e.mdu_op    = ins[14:12];
    end
    e.illegal = (cls == 10);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int          pick;
    ins  = $urandom;
    pick = $urandom_range(0, 11);
    case (pick)
      0:  ins[6:0] = 7'b0000011;
      1:  ins[6:0] = 7'b0100011;
      2:  begin ins[6:0] = 7'b0110011; ins[31:25] = ($urandom % 2 == 0) ? 7'h00 : 7'h20; end
      3:  ins[6:0] = 7'b0010011;
      4:  ins[6:0] = 7'b1100011;
      5:  ins[6:0] = 7'b1101111;
      6:  ins[6:0] = 7'b1100111;
      7:  ins[6:0] = 7'b0110111;
      8:  ins[6:0] = 7'b0010111;
      9:  begin ins[6:0] = 7'b0110011; ins[31:25] = 7'h01; end
      10: ins[6:0] = 7'b0110011;
      default: ;
    endcase
    return ins;
  endfunction

  // Reference model state and scoreboard queues
  int     m_cnt = 0;
  bit     m_ready;
  bit     m_acc;
  int     kind;
  tb_ex_t e_new;
  int     kind_q[$];
  tb_ex_t exp_q[$];

  // Model step just before each rising edge: check handshake, predict next EX contents
  always @(negedge clk) begin
    #3;
    m_ready = !rst && !stall_i && !flush_i && (m_cnt == 0);
    chk("ready_o", 64'(ready_o), 64'(m_ready));
    chk("busy_o", 64'(busy_o), 64'(m_cnt != 0));
    m_acc = valid_i && m_ready;
    if (rst) begin
      m_cnt = 0;
      kind  = 0;
    end else begin
      if (flush_i)         kind = 0;
      else if (stall_i)    kind = 2;
      else if (m_cnt != 0) kind = 0;
      else if (m_acc)      kind = 1;
      else                 kind = 0;
      if (m_acc) begin
        e_new = model(instr_i, 1'b1);
        exp_q.push_back(e_new);
        if (e_new.mdu_start) m_cnt = instr_i[14] ? DIV_LAT : MUL_LAT;
      end else if (m_cnt != 0) begin
        m_cnt = flush_i ? 0 : m_cnt - 1;
      end
    end
    kind_q.push_back(kind);
  end

  tb_ex_t act, want, last;
  int     mk;

  // Monitor: compare the EX register against the scoreboard each cycle
  always @(negedge clk) begin
    if (kind_q.size() > 0) begin
      mk = kind_q.pop_front();
      act.valid = valid_e;             act.reg_write = reg_write_e;
      act.mem_write = mem_write_e;     act.alu_src = alu_src_e;
      act.branch = branch_e;           act.jump = jump_e;
      act.jal_jalr_sel = jal_jalr_sel_e; act.loadimm_sel = loadimm_sel_e;
      act.auipc = auipc_e;             act.result_src = result_src_e;
      act.alu_control = alu_control_e; act.imm_src = imm_src_e;
      act.funct3 = funct3_e;           act.mdu_start = mdu_start_e;
      act.mdu_op = mdu_op_e;           act.illegal = illegal_e;
      want = '0;
      if (mk == 1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_empty actual=%h t=%0t", act, $time);
        end else begin
          want = exp_q.pop_front();
        end
      end else if (mk == 2) begin
        want = last;
        want.mdu_start = 1'b0;
      end
      chk(mk == 1 ? "ex_new" : (mk == 2 ? "ex_hold" : "ex_bubble"), 64'(act), 64'(want));
      last = want;
    end
  end

  task automatic step(input logic r, input logic v, input logic s, input logic f,
                      input logic [31:0] ins);
    @(negedge clk);
    #1;
    rst = r; valid_i = v; stall_i = s; flush_i = f; instr_i = ins;
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; instr_i = '0;
    valid2 = 1'b0; instr2 = '0;
    last = '0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // Basic ALU ops
    step(0, 1, 0, 0, 32'h00500093);
    step(0, 1, 0, 0, 32'h40208033);
    step(0, 1, 0, 0, 32'h00208033);
    // mul, with a held-off request while busy
    step(0, 1, 0, 0, 32'h022081B3);
    step(0, 1, 0, 0, 32'h00208033);
    step(0, 1, 0, 0, 32'h00208033);
    step(0, 0, 0, 0, 0);
    // div with a stall pulse mid-way
    step(0, 1, 0, 0, 32'h0220C1B3);
    for (int i = 1; i <= 36; i++) step(0, 0, (i == 15 || i == 16), 0, 0);
    // second div flushed at cycle 10
    step(0, 1, 0, 0, 32'h0220C1B3);
    for (int i = 1; i <= 9; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 32'h00500093);
    step(0, 0, 0, 0, 0);
    // undefined opcode
    step(0, 1, 0, 0, 32'h0000007F);
    // M group on the no-M build is illegal and never busies
    valid2 = 1'b1;
    instr2 = 32'h022081B3;
    step(0, 0, 0, 0, 0);
    chk("nom_valid_e", 64'(valid_e2), 64'(1));
    chk("nom_illegal_e", 64'(illegal2), 64'(1));
    chk("nom_wr_en", 64'({reg_write2, mem_write2, mdu_start2}), 64'(0));
    valid2 = 1'b0;
    step(0, 0, 0, 0, 0);
    chk("nom_busy_o", 64'(busy2), 64'(0));
    chk("nom_ready_o", 64'(ready2), 64'(1));
    // mul followed by a 3-cycle stall
    step(0, 1, 0, 0, 32'h022081B3);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    // reset mid-BUSY
    step(0, 1, 0, 0, 32'h0220C1B3);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom % 500) == 0, ($urandom % 4) != 0, ($urandom % 10) == 0,
           ($urandom % 20) == 0, rand_instr());
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_decode_ctrl_stage.md
Name: rv_decode_ctrl_stage

Overview:
- Registered successor to the combinational RV32I main/ALU decoder; sits between the IF/ID register and the execute stage.
- Produces the ID/EX control register directly. Adds AUIPC, branch/load/store sub-type passthrough, illegal-instruction flagging and optional M-extension issue.
- A small FSM holds off fetch while a multi-cycle mul/div runs.

Parameters:
- EN_MEXT, 1: 1 decodes MUL/DIV group; 0 flags it illegal.
- MUL_LAT, 2: busy cycles after a MUL* issue, range 1..255.
- DIV_LAT, 33: busy cycles after a DIV*/REM* issue, range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr_i  in  32  instruction from IF/ID
- valid_i  in  1  instr_i holds a real instruction
- stall_i  in  1  hazard unit: hold EX register, accept nothing
- flush_i  in  1  branch/jump redirect: kill EX register and any busy MDU
- ready_o  out  1  stage accepts instr_i this cycle
- busy_o  out  1  MDU FSM in BUSY
- valid_e  out  1  EX register holds a live op
- reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e, jal_jalr_sel_e, loadimm_sel_e, auipc_e  out  1 each  EX control bits
- result_src_e  out  2  00 ALU, 01 mem, 10 PC+4, 11 MDU
- alu_control_e  out  5  ALU op code
- imm_src_e  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- funct3_e  out  3  branch compare / load-store size passthrough
- mdu_start_e  out  1  one-cycle start pulse to MDU
- mdu_op_e  out  3  funct3 of M instruction
- illegal_e  out  1  undecodable opcode/funct

Behaviour:
- Reset: all *_e outputs 0, busy_o 0, FSM IDLE, counter 0. ready_o = 0 during reset, then combinational.
- ready_o = ~stall_i & ~flush_i & (state==IDLE). Accept = valid_i & ready_o.
- EX register update priority:
  - rst
  - flush_i: bubble, all 0
  - stall_i: hold
  - BUSY: bubble
  - accept: decoded fields
  - otherwise: bubble
- Latency: decoded fields appear 1 cycle after accept.
- Opcode decode:
  - lw 0000011: rs01, alu_src, reg_write, imm I.
  - sw 0100011: mem_write, alu_src, imm S.
  - R 0110011: reg_write, rs00.
  - I 0010011: reg_write, alu_src, imm I.
  - branch 1100011: branch, imm B, ALU 00001.
  - jal 1101111: jump, reg_write, rs10, imm J, jal_jalr_sel 0.
  - jalr 1100111: jump, reg_write, rs10, alu_src, imm I, jal_jalr_sel 1.
  - lui 0110111: reg_write, alu_src, loadimm_sel, imm U.
  - auipc 0010111: reg_write, alu_src, auipc, imm U, ALU 00000.
- Unused control bits are driven 0, never x.
- ALU codes (funct3): 000 add 00000 / sub 00001; 001 sll 00100; 010 slt 00101; 011 sltu 01000; 100 xor 01010; 101 srl 01110 / sra 00111; 110 or 00011; 111 and 00010.
- Sub applies only for R-type with instr[30]=1. sra applies for R/I with instr[30]=1.
- Loads, stores and jumps use ALU add. funct3_e = instr[14:12] for every accepted op.
- M group: opcode 0110011 with funct7=0000001 and EN_MEXT=1.
  - Outputs: reg_write, rs11, mdu_start_e=1, mdu_op_e=funct3.
  - Same cycle, FSM goes IDLE->BUSY. Counter loads MUL_LAT if funct3[2]=0, else DIV_LAT.
- Illegal:
  - Any other opcode, an R-type funct7 not in {0000000, 0100000}, or the M group with EN_MEXT=0.
  - Result: valid_e=1, illegal_e=1, all write enables 0.
- FSM:
  - BUSY decrements every cycle, including under stall_i, and returns to IDLE when counter reaches 1.
  - ready_o therefore stays low for exactly LAT cycles after the issue cycle.
  - flush_i in BUSY forces IDLE and counter 0 next cycle.
- mdu_start_e is 1 for exactly one cycle per issue. Under stall_i in the issue-following cycle it is cleared (the held copy keeps mdu_start_e=0) so the MDU never restarts.
- flush_i together with an accept: the instruction is dropped (ready_o already 0).
- rst has priority over everything, including mid-BUSY.

Test Plan:
- Reset then valid_i=1, instr 0x00500093 (addi x1,x0,5): next cycle valid_e=1, reg_write_e=1, alu_src_e=1, alu_control_e=00000, imm_src_e=000, illegal_e=0.
- instr 0x40208033 (sub x0,x1,x2): alu_control_e=00001, alu_src_e=0; then 0x00208033 (add) gives 00000.
- instr 0x022081B3 (mul x3,x1,x2), MUL_LAT=2:
  - mdu_start_e=1 for one cycle, result_src_e=11, mdu_op_e=000.
  - ready_o=0 for exactly 2 cycles, 1 on the third.
- instr 0x0220C1B3 (div), DIV_LAT=33:
  - busy_o high 33 cycles, with stall_i pulsed mid-way without stretching it.
  - flush_i at cycle 10 of a second div: busy_o=0 and ready_o=1 next cycle.
- Opcode 1111111, then EN_MEXT=0 build with 0x022081B3: illegal_e=1, reg_write_e=0, mem_write_e=0, mdu_start_e=0.
- Issue mul, then stall_i=1 for 3 cycles: EX fields held, mdu_start_e=1 only in the first cycle. rst asserted mid-BUSY: all outputs 0 next cycle.
